// File: rtl/ahb_slave_if.sv
// AHB slave front-end of the AHB2APB bridge: decodes three APB regions and hands one request at a time to the APB controller.
// Optional SEQ address continuity checking is built when AHB_BURST_CHECK_EN is defined.
module ahb_slave_if #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] REGION_BASE = 32'h8000_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [2:0]        req_size,
    output logic [2:0]        req_sel,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_REQ  = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_ERR1    = 3'd5,
        S_ERR2    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] P_BASE = ADDR_W'(REGION_BASE);
    localparam logic [ADDR_W-1:0] P_SIZE = ADDR_W'(REGION_SIZE);
    localparam logic [ADDR_W-1:0] P_LIM1 = P_BASE + P_SIZE;
    localparam logic [ADDR_W-1:0] P_LIM2 = P_LIM1 + P_SIZE;
    localparam logic [ADDR_W-1:0] P_LIM3 = P_LIM2 + P_SIZE;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_hrdata;
    logic                r_req_write;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [2:0]          r_req_size;
    logic [2:0]          r_req_sel;

    logic                w_active;
    logic                w_accept;
    logic [2:0]          w_sel;
    logic                w_burst_bad;
    logic                w_ok;
    logic                w_hreadyout;
    logic [1:0]          w_hresp;
    logic                w_req_valid;

    assign w_active = (htrans == 2'b10) || (htrans == 2'b11);
    // Only IDLE and ERR2 drive hreadyout high, so only they can take a new address phase.
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_ERR2)) && hreadyin && w_active;

    assign w_sel[0] = (haddr >= P_BASE) && (haddr < P_LIM1);
    assign w_sel[1] = (haddr >= P_LIM1) && (haddr < P_LIM2);
    assign w_sel[2] = (haddr >= P_LIM2) && (haddr < P_LIM3);

`ifdef AHB_BURST_CHECK_EN
    logic [ADDR_W-1:0] r_last_addr;
    logic [2:0]        r_last_size;
    logic              r_last_vld;
    logic [ADDR_W-1:0] w_exp_addr;

    assign w_exp_addr  = r_last_addr + (ADDR_W'(1) << r_last_size);
    assign w_burst_bad = (htrans == 2'b11) && (!r_last_vld || (haddr != w_exp_addr));

    // Any errored address phase breaks the burst chain; a fresh NONSEQ is needed.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_last_addr <= '0;
            r_last_size <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_accept) begin
            if (w_ok) begin
                r_last_addr <= haddr;
                r_last_size <= hsize;
                r_last_vld  <= 1'b1;
            end else begin
                r_last_vld  <= 1'b0;
            end
        end
    end
`else
    assign w_burst_bad = 1'b0;
`endif

    assign w_ok = (|w_sel) && !w_burst_bad;

    always_comb begin
        w_next      = r_state;
        w_hreadyout = 1'b0;
        w_hresp     = 2'b00;
        w_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hreadyout = 1'b1;
                if (w_accept)
                    w_next = !w_ok ? S_ERR1 : (hwrite ? S_WR_DATA : S_RD_REQ);
            end
            S_WR_DATA: w_next = S_WR_REQ;
            S_WR_REQ: begin
                w_req_valid = 1'b1;
                if (req_ready) w_next = S_IDLE;
            end
            S_RD_REQ: begin
                w_req_valid = 1'b1;
                if (req_ready) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rsp_valid) w_next = S_IDLE;
            end
            S_ERR1: begin
                w_hresp = 2'b01;
                w_next  = S_ERR2;
            end
            S_ERR2: begin
                w_hreadyout = 1'b1;
                w_hresp     = 2'b01;
                if (w_accept)
                    w_next = !w_ok ? S_ERR1 : (hwrite ? S_WR_DATA : S_RD_REQ);
                else
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_hrdata    <= '0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_size  <= '0;
            r_req_sel   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req_addr  <= haddr;
                r_req_write <= hwrite;
                r_req_size  <= hsize;
                r_req_sel   <= w_sel;
            end
            if (r_state == S_WR_DATA)
                r_req_wdata <= hwdata;
            if ((r_state == S_RD_WAIT) && rsp_valid)
                r_hrdata <= rsp_rdata;
        end
    end

    assign hreadyout = w_hreadyout;
    assign hresp     = w_hresp;
    assign hrdata    = r_hrdata;
    assign req_valid = w_req_valid;
    assign req_write = r_req_write;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_size  = r_req_size;
    assign req_sel   = r_req_sel;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Scoreboard bench for ahb_slave_if: stimulus pushes expected requests/completions, a negedge monitor pops and compares.
module tb_ahb_slave_if;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic [2:0]  req_sel;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    ahb_slave_if dut (
        .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  sel;
        logic [2:0]  size;
    } req_t;

    typedef struct {
        logic [1:0]  resp;
        logic        rd;
        logic [31:0] rdata;
    } cpl_t;

    req_t q_req[$];
    cpl_t q_cpl[$];

    int n_cmp = 0;
    int n_err = 0;
    int stall = 0;
    int rsp_delay = 3;
    int wcnt = 0;
    int rsp_cnt = 0;
    logic pending = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready/response driver and monitor share one process so their ordering per cycle is fixed.
    initial begin
        req_t r;
        cpl_t c;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                pending   = 1'b0;
                req_ready = 1'b0;
            end else begin
                if (req_valid) begin
                    if (wcnt >= stall) req_ready = 1'b1;
                    else begin req_ready = 1'b0; wcnt++; end
                end else begin
                    req_ready = 1'b0;
                end
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    rsp_valid = (rsp_cnt == 0);
                end else begin
                    rsp_valid = 1'b0;
                end
                if (req_valid && req_ready) begin
                    wcnt = 0;
                    if (q_req.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_req: got addr %0h expected no request", req_addr);
                    end else begin
                        r = q_req.pop_front();
                        chk("req_write", req_write, r.wr);
                        chk("req_addr", req_addr, r.addr);
                        chk("req_sel", req_sel, r.sel);
                        chk("req_size", req_size, r.size);
                        if (r.wr) chk("req_wdata", req_wdata, r.wdata);
                    end
                    if (!req_write) rsp_cnt = rsp_delay;
                end
                if (pending && hreadyout) begin
                    pending = 1'b0;
                    if (q_cpl.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_cpl: got hresp %0h expected none", hresp);
                    end else begin
                        c = q_cpl.pop_front();
                        chk("cpl_hresp", hresp, c.resp);
                        if (c.rd) chk("cpl_hrdata", hrdata, c.rdata);
                    end
                end
                if (hreadyout && hreadyin && htrans[1]) pending = 1'b1;
            end
        end
    end

    task automatic xfer(input logic wr, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [2:0] sel,
                        input logic err, input logic [31:0] rd,
                        output int lowcnt, output logic [1:0] first_resp);
        req_t r;
        cpl_t c;
        logic rdy;
        int   t;
        if (!err) begin
            r.wr = wr; r.addr = a; r.wdata = wd; r.sel = sel; r.size = sz;
            q_req.push_back(r);
        end
        c.resp = err ? 2'b01 : 2'b00;
        c.rd = !wr && !err;
        c.rdata = rd;
        q_cpl.push_back(c);
        htrans = tr; haddr = a; hwrite = wr; hsize = sz;
        rdy = 1'b0; t = 0;
        while (!rdy && t < 50) begin
            @(negedge hclk); rdy = hreadyout;
            @(posedge hclk); #1; t++;
        end
        chk("addr_accept", rdy, 1'b1);
        htrans = 2'b00; hwdata = wd;
        lowcnt = 0; first_resp = 2'b00; rdy = 1'b0; t = 0;
        while (!rdy && t < 100) begin
            @(negedge hclk); rdy = hreadyout;
            if (t == 0) first_resp = hresp;
            if (!rdy) lowcnt++;
            @(posedge hclk); #1; t++;
        end
        chk("data_done", rdy, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        int lc;
        logic [1:0] fr;
        hreset = 1'b1; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00; hsize = 3'd0;
        haddr = '0; hwdata = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (3) @(posedge hclk); #1;
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 2'b00);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_req_sel", req_sel, 3'b000);
        chk("rst_req_wdata", req_wdata, 32'h0);
        chk("rst_req_write_size", {req_write, req_size}, 4'h0);
        hreset = 1'b0;

        // reset while waiting for read data
        rsp_delay = 8; rsp_rdata = 32'hDEAD_BEEF;
        r.wr = 1'b0; r.addr = 32'h8000_0020; r.wdata = '0; r.sel = 3'b001; r.size = 3'd2;
        q_req.push_back(r);
        hwrite = 1'b0; haddr = 32'h8000_0020; hsize = 3'd2; htrans = 2'b10;
        @(posedge hclk); #1;
        htrans = 2'b00;
        repeat (2) @(posedge hclk); #1;
        chk("rd_wait_hreadyout", hreadyout, 1'b0);
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        chk("midrst_hreadyout", hreadyout, 1'b1);
        chk("midrst_req_valid", req_valid, 1'b0);
        repeat (10) @(posedge hclk); #1;
        chk("midrst_hrdata", hrdata, 32'h0);

        // single write, ready tied high
        stall = 0;
        xfer(1'b1, 2'b10, 32'h8000_0001, 3'd0, 32'h80, 3'b001, 1'b0, 32'h0, lc, fr);
        chk("wr_low_cycles", lc, 2);

        // single read
        rsp_delay = 3; rsp_rdata = 32'hA5;
        xfer(1'b0, 2'b10, 32'h8400_0010, 3'd2, 32'h0, 3'b010, 1'b0, 32'hA5, lc, fr);

        // unmapped
        xfer(1'b1, 2'b10, 32'h9000_0000, 3'd2, 32'h1, 3'b000, 1'b1, 32'h0, lc, fr);
        chk("err_first_hresp", fr, 2'b01);
        chk("err_low_cycles", lc, 1);
        @(negedge hclk);
        chk("err_after_hresp", hresp, 2'b00);
        @(posedge hclk); #1;

        // burst write with stalled ready
        stall = 2;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h8800_1000 + i, 3'd0, 32'h11 * (i + 1),
                 3'b100, 1'b0, 32'h0, lc, fr);
        stall = 0;

        // SEQ with a discontinuous address
        xfer(1'b1, 2'b10, 32'h8800_1001, 3'd0, 32'h55, 3'b100, 1'b0, 32'h0, lc, fr);
`ifdef AHB_BURST_CHECK_EN
        xfer(1'b1, 2'b11, 32'h8800_1005, 3'd0, 32'h66, 3'b100, 1'b1, 32'h0, lc, fr);
        chk("seq_bad_first_hresp", fr, 2'b01);
`else
        xfer(1'b1, 2'b11, 32'h8800_1005, 3'd0, 32'h66, 3'b100, 1'b0, 32'h0, lc, fr);
        chk("seq_plain_first_hresp", fr, 2'b00);
`endif

        // region boundaries
        rsp_delay = 1;
        xfer(1'b1, 2'b10, 32'h8BFF_FFFF, 3'd0, 32'h77, 3'b100, 1'b0, 32'h0, lc, fr);
        xfer(1'b0, 2'b10, 32'h8C00_0000, 3'd0, 32'h0, 3'b000, 1'b1, 32'h0, lc, fr);
        xfer(1'b1, 2'b10, 32'h7FFF_FFFF, 3'd0, 32'h0, 3'b000, 1'b1, 32'h0, lc, fr);
        rsp_rdata = 32'h1234_5678;
        xfer(1'b0, 2'b10, 32'h83FF_FFFF, 3'd0, 32'h0, 3'b001, 1'b0, 32'h1234_5678, lc, fr);
        xfer(1'b1, 2'b10, 32'h8400_0000, 3'd2, 32'hCAFE_F00D, 3'b010, 1'b0, 32'h0, lc, fr);

        // BUSY transfers do nothing
        htrans = 2'b01; haddr = 32'h8000_0000; hwrite = 1'b1;
        repeat (3) @(posedge hclk); #1;
        chk("busy_hreadyout", hreadyout, 1'b1);
        chk("busy_hresp", hresp, 2'b00);
        htrans = 2'b00;
        repeat (3) @(posedge hclk); #1;

        chk("req_queue_empty", q_req.size(), 0);
        chk("cpl_queue_empty", q_cpl.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB slave front-end of the AHB2APB bridge; sits directly downstream of ahb_master.
- Samples AHB address phases, decodes one of three APB slave regions, and captures write data.
- Presents one request at a time to the APB-side controller over a valid/ready request channel and a response channel.
- Drives hreadyout/hresp/hrdata back to the master, including a two-cycle ERROR for unmapped addresses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
REGION_BASE, 32'h8000_0000, base of slave 0; slaves 1/2 follow contiguously
REGION_SIZE, 32'h0400_0000, bytes per slave region

Ports:
hclk  in  1  clock
hreset  in  1  synchronous, active-high reset
hwrite  in  1  1=write, 0=read
hreadyin  in  1  bus ready; address phase is ignored when 0
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  in  3  transfer size
haddr  in  ADDR_W  address
hwdata  in  DATA_W  write data, valid in the data phase
hreadyout  out  1  data-phase complete
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_W  read data
req_valid  out  1  request to APB controller
req_ready  in  1  request accepted
req_write  out  1  request direction
req_addr  out  ADDR_W  registered address
req_wdata  out  DATA_W  registered write data
req_size  out  3  registered hsize
req_sel  out  3  one-hot slave select
rsp_valid  in  1  read data returned
rsp_rdata  in  DATA_W  read data

Behaviour:
- Reset: all registers clear at a rising hclk edge with hreset=1; overrides everything, including a mid-transfer state.
  - Reset values: state=IDLE, hreadyout=1, hresp=00, hrdata=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_size=0, req_sel=000.
- Accept: an address phase is accepted at an edge where hreadyout=1, hreadyin=1 and htrans[1]=1. This is possible only in state IDLE or ERR2.
  - BUSY and IDLE transfers produce no action and an OKAY response.
- Decode: a region is valid when REGION_BASE <= haddr < REGION_BASE+3*REGION_SIZE.
  - req_sel = 001, 010 or 100 for the first, second or third region.
  - Comparisons are ADDR_W-bit unsigned.
- On accept, haddr, hwrite, hsize and req_sel are registered.
- FSM:
  - IDLE: hreadyout=1, hresp=00.
    - Valid write → WR_DATA.
    - Valid read → RD_REQ.
    - Unmapped address → ERR1.
  - WR_DATA: hreadyout=0. Capture hwdata into req_wdata at the edge → WR_REQ.
  - WR_REQ: req_valid=1, hreadyout=0, all req_* stable. On req_ready → IDLE, with req_valid=0 on the next cycle.
  - RD_REQ: req_valid=1, hreadyout=0. On req_ready → RD_WAIT. rsp_valid is ignored in this state.
  - RD_WAIT: hreadyout=0. On rsp_valid, hrdata<=rsp_rdata → IDLE. hrdata then holds until the next read response.
  - ERR1: hreadyout=0, hresp=01 → ERR2.
  - ERR2: hreadyout=1, hresp=01 → IDLE, unless a new address phase is accepted at this edge (handled as from IDLE).
- Latency with req_ready tied high:
  - Write: accept at E0, request accepted at E2, hreadyout high after E2.
  - Read: request accepted at E1; completion is 1 cycle after rsp_valid.
- Exactly one outstanding request at a time. req_ready while req_valid=0 is ignored; rsp_valid outside RD_WAIT is ignored.
- Back-to-back transfers: the next address is accepted at the same edge the current data phase completes (pipelined).

Optional Feature:
- Macro: AHB_BURST_CHECK_EN.
- With the macro defined:
  - Holds last accepted address and size.
  - A SEQ whose haddr != last_addr + (1<<last_hsize), or a SEQ with no prior NONSEQ since reset/error, takes the ERR1/ERR2 path with no request.
- Without the macro: SEQ is handled identically to NONSEQ, and no tracking registers are built.

Test Plan:
- Reset mid-read: hreset=1 pulsed while in RD_WAIT → next cycle hreadyout=1, req_valid=0; a later rsp_valid leaves hrdata=0.
- Single write: NONSEQ haddr=32'h8000_0001, hwdata=8'h80, req_ready=1 → req_valid for 1 cycle with req_addr=32'h8000_0001, req_wdata=32'h80, req_sel=001; hreadyout low for exactly 2 cycles.
- Single read: haddr=32'h8400_0010, rsp_valid 3 cycles after req accept with rsp_rdata=32'hA5 → req_sel=010; hrdata=32'hA5 when hreadyout returns high; hresp=00.
- Unmapped: NONSEQ haddr=32'h9000_0000 → no req_valid; hresp=01 for 2 cycles, hreadyout 0 then 1; then hresp=00.
- Burst write: 4 beats starting at haddr=32'h8800_1000 (NONSEQ then SEQ +1, hsize=0), req_ready stalled 2 cycles per beat → 4 requests in order with addresses 1000..1003 and req_sel=100; no beat lost.
- AHB_BURST_CHECK_EN: SEQ to 32'h8800_1005 after 32'h8800_1001 (hsize=0) → ERROR response, no request; with the macro undefined → normal request.
